// File: rtl/fifo_wr_arbiter.sv
// Packet round-robin arbiter sharing one async FIFO write port.
// Define FIFO_ARB_TAG_EN to prepend the owner index to fifo_din.
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DSIZE   = 8,
  parameter int ASIZE   = 4,
  parameter int MAX_PKT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
`ifdef FIFO_ARB_TAG_EN
  output logic [DSIZE+$clog2(NREQ)-1:0] fifo_din,
`else
  output logic [DSIZE-1:0]       fifo_din,
`endif
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  input  logic [ASIZE:0]         fifo_wr_count,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   err_long
);

  localparam int SEL_W = $clog2(NREQ);
  localparam int DEPTH = 2**ASIZE;
  localparam int CNT_W = $clog2(MAX_PKT+1);

  localparam logic [ASIZE:0] THRESH =
    (ASIZE+1)'(DEPTH-MAX_PKT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_PKT);
  localparam logic [CNT_W-1:0] CNT_ERR =
    CNT_W'(MAX_PKT-1);
  localparam logic [NREQ-1:0] ONE =
    {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [SEL_W-1:0] own;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] nxt_ptr;
  logic [SEL_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic             space_ok;
  logic             acc;
  logic             last;
  logic [DSIZE-1:0] data_arr [NREQ];

  // Split the flat data bus into per-requester words
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*DSIZE +: DSIZE];
    end
  end

  // First valid requester searching upward from rr_ptr
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] sel;
    idx   = 0;
    sel   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = SEL_W'(idx);
      if (!found && req_valid[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
  end

  assign space_ok = (fifo_wr_count <= THRESH);
  assign nxt_ptr  = (own == SEL_W'(NREQ-1))
                    ? '0 : own + 1'b1;
  assign busy     = (state == XFER);
  assign acc      = fifo_wr_en;
  assign last     = req_last[own];

  // Datapath steering from the registered owner
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == XFER) begin
      req_ready  = grant & {NREQ{~fifo_full}};
      fifo_wr_en = req_valid[own] & ~fifo_full;
`ifdef FIFO_ARB_TAG_EN
      fifo_din   = {own, data_arr[own]};
`else
      fifo_din   = data_arr[own];
`endif
    end
  end

  // Arbitration FSM, beat counter and overlength flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      own      <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      err_long <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_long <= 1'b0;
          if (found && space_ok) begin
            grant <= ONE << win;
            own   <= win;
            state <= XFER;
          end
        end
        XFER: begin
          err_long <= acc && !last
                      && (cnt == CNT_ERR);
          if (acc) begin
            if (last) begin
              state  <= IDLE;
              grant  <= '0;
              cnt    <= '0;
              rr_ptr <= nxt_ptr;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter.
// Default parameters: NREQ=4 DSIZE=8 ASIZE=4 MAX_PKT=8.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
`ifdef FIFO_ARB_TAG_EN
  logic [9:0]  fifo_din;
`else
  logic [7:0]  fifo_din;
`endif
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [4:0]  fifo_wr_count;
  logic [3:0]  grant;
  logic        busy;
  logic        err_long;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ(4), .DSIZE(8), .ASIZE(4), .MAX_PKT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full),
    .fifo_wr_count(fifo_wr_count),
    .grant(grant),
    .busy(busy),
    .err_long(err_long)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    fifo_full = 1'b0; fifo_wr_count = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({grant, busy, fifo_wr_en, req_ready,
         err_long, fifo_din} !== '0) begin
      errors++;
      $display("FAIL reset_hold got g=%b b=%b we=%b rdy=%b e=%b din=%h exp all 0",
               grant, busy, fifo_wr_en, req_ready,
               err_long, fifo_din);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({grant, busy, fifo_wr_en, req_ready,
         err_long, fifo_din} !== '0) begin
      errors++;
      $display("FAIL reset_release got g=%b b=%b we=%b din=%h exp all 0",
               grant, busy, fifo_wr_en, fifo_din);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int         beat [4];
    logic [3:0] acc;
    int         o;
    logic [3:0] eg;
    logic       ew;
    logic [7:0] ed;
    for (int i = 0; i < 4; i++) beat[i] = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = 4'hf;
      for (int i = 0; i < 4; i++) begin
        req_data[i*8 +: 8] = {4'(i), 4'(beat[i])};
        req_last[i] = (beat[i] == 2);
      end
      #1;
      o = (c / 4) % 4;
      if (c % 4 == 0) begin
        eg = 4'b0; ew = 1'b0; ed = 8'h00;
      end else begin
        eg = 4'b0001 << o;
        ew = 1'b1;
        ed = {4'(o), 4'(c % 4 - 1)};
      end
      checks++;
      if ({grant, fifo_wr_en, busy, fifo_din[7:0]}
          !== {eg, ew, ew, ed}) begin
        errors++;
        $display("FAIL rr_seq c=%0d got g=%b we=%b b=%b din=%h exp g=%b we=%b din=%h",
                 c, grant, fifo_wr_en, busy,
                 fifo_din[7:0], eg, ew, ed);
      end
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < 4; i++)
        if (acc[i]) beat[i] = (beat[i] == 2) ? 0 : beat[i] + 1;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_space_gate();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    req_data[23:16] = 8'h77;
    fifo_wr_count = 5'd9;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL gate_cnt9 got g=%b exp 0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gate_cnt9_hold got g=%b b=%b exp 0000 0",
               grant, busy);
    end
    fifo_wr_count = 5'd8;
    step();
    #1;
    checks++;
    if ({grant, fifo_wr_en, fifo_din[7:0]}
        !== {4'b0100, 1'b1, 8'h77}) begin
      errors++;
      $display("FAIL gate_cnt8 got g=%b we=%b din=%h exp 0100 1 77",
               grant, fifo_wr_en, fifo_din[7:0]);
    end
    step();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_beat got b=%b g=%b exp 0 0000",
               busy, grant);
    end
    req_valid = '0;
    req_last  = '0;
    fifo_wr_count = '0;
  endtask

  task automatic test_full_stall();
    logic [7:0] q [$];
    int   beat;
    logic acc;
    logic ew;
    beat = 0;
    req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      fifo_full = (c == 3 || c == 4);
      req_data[15:8] = 8'hA0 + 8'(beat);
      req_last[1] = (beat == 4);
      #1;
      if (c >= 1) begin
        ew = ~fifo_full;
        checks++;
        if ({req_ready[1], fifo_wr_en, grant}
            !== {ew, ew, 4'b0010}) begin
          errors++;
          $display("FAIL stall c=%0d got rdy=%b we=%b g=%b exp %b %b 0010",
                   c, req_ready[1], fifo_wr_en, grant, ew, ew);
        end
      end
      if (fifo_wr_en) q.push_back(fifo_din[7:0]);
      acc = req_valid[1] & req_ready[1];
      step();
      if (acc) beat++;
    end
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    checks++;
    if (q.size() != 5) begin
      errors++;
      $display("FAIL stall_count got %0d exp 5", q.size());
    end
    for (int k = 0; k < q.size(); k++) begin
      checks++;
      if (q[k] !== 8'hA0 + 8'(k)) begin
        errors++;
        $display("FAIL stall_data k=%0d got %h exp %h",
                 k, q[k], 8'hA0 + 8'(k));
      end
    end
  endtask

  task automatic test_err_long();
    int   beat;
    int   accepted;
    int   writes;
    int   pulses;
    int   err_at;
    logic acc;
    beat = 0; accepted = 0; writes = 0;
    pulses = 0; err_at = -1;
    req_valid = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      if (c == 11) req_valid = '0;
      req_data[15:8] = 8'h10 + 8'(beat);
      req_last[1] = (beat == 9);
      #1;
      if (fifo_wr_en) writes++;
      if (err_long) begin
        pulses++;
        err_at = accepted;
      end
      acc = req_valid[1] & req_ready[1];
      step();
      if (acc) begin
        beat++;
        accepted++;
      end
    end
    req_last = '0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL err_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (err_at != 8) begin
      errors++;
      $display("FAIL err_timing got after %0d beats exp 8", err_at);
    end
    checks++;
    if (writes != 10) begin
      errors++;
      $display("FAIL err_writes got %0d exp 10", writes);
    end
  endtask

  task automatic test_reset_mid_packet();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    req_data[23:16] = 8'hC0;
    step();
    req_data[23:16] = 8'hC1;
    step();
    req_data[23:16] = 8'hC2;
    #1;
    checks++;
    if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got g=%b we=%b exp 0100 1",
               grant, fifo_wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, busy, fifo_wr_en, req_ready,
         err_long, fifo_din} !== '0) begin
      errors++;
      $display("FAIL mid_reset got g=%b b=%b we=%b rdy=%b din=%h exp all 0",
               grant, busy, fifo_wr_en, req_ready, fifo_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    req_data  = 32'hD3_00_D1_00;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got g=%b exp 0000", grant);
    end
    step();
    #1;
    checks++;
    if ({grant, fifo_wr_en, fifo_din[7:0]}
        !== {4'b0010, 1'b1, 8'hD1}) begin
      errors++;
      $display("FAIL post_reset_grant got g=%b we=%b din=%h exp 0010 1 d1",
               grant, fifo_wr_en, fifo_din[7:0]);
    end
    step();
    req_valid = '0;
    req_last  = '0;
    step();
  endtask

`ifdef FIFO_ARB_TAG_EN
  task automatic test_tag();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    req_data[31:24] = 8'h5A;
    step();
    #1;
    checks++;
    if (fifo_din !== {2'b11, 8'h5A}) begin
      errors++;
      $display("FAIL tag got %h exp %h",
               fifo_din, {2'b11, 8'h5A});
    end
    step();
    req_valid = '0;
    req_last  = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_space_gate();
    test_full_stall();
    test_err_long();
    test_reset_mid_packet();
`ifdef FIFO_ARB_TAG_EN
    test_tag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
